// File: rtl/memory_arbiter.sv
// Shared-memory arbiter: per-core icache/dcache ports onto a single RAM port.
// Dcache beats icache, cores rotate round-robin, dcache two-word blocks hold the grant.
module memory_arbiter #(
    parameter int CPUS = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [CPUS-1:0]            iREN,
    input  logic [CPUS-1:0][31:0]      iaddr,
    output logic [CPUS-1:0]            iwait,
    output logic [CPUS-1:0][31:0]      iload,
    input  logic [CPUS-1:0]            dREN,
    input  logic [CPUS-1:0]            dWEN,
    input  logic [CPUS-1:0][31:0]      daddr,
    input  logic [CPUS-1:0][31:0]      dstore,
    output logic [CPUS-1:0]            dwait,
    output logic [CPUS-1:0][31:0]      dload,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [31:0]                ramaddr,
    output logic [31:0]                ramstore,
    input  logic [31:0]                ramload,
    input  logic [1:0]                 ramstate
);

    localparam int RRW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t          r_state;
    logic [RRW-1:0]  r_owner;
    logic [RRW-1:0]  r_rr;

    logic [CPUS-1:0] w_dreq;
    logic            w_dfound;
    logic            w_ifound;
    logic [RRW-1:0]  w_dsel;
    logic [RRW-1:0]  w_isel;
    logic            w_complete;
    logic [RRW-1:0]  w_rr_next;

    assign w_dreq     = dREN | dWEN;
    assign w_complete = (ramstate == RAM_ACCESS);
    assign w_rr_next  = (r_owner == RRW'(CPUS - 1)) ? '0 : r_owner + 1'b1;

    // Scan from the round-robin pointer upward with wrap; first hit wins.
    always_comb begin
        logic [RRW:0]   v_sum;
        logic [RRW-1:0] v_cand;
        w_dfound = 1'b0;
        w_ifound = 1'b0;
        w_dsel   = '0;
        w_isel   = '0;
        v_sum    = '0;
        v_cand   = '0;
        for (int k = 0; k < CPUS; k++) begin
            v_sum = {1'b0, r_rr} + (RRW+1)'(k);
            if (v_sum >= (RRW+1)'(CPUS))
                v_sum = v_sum - (RRW+1)'(CPUS);
            v_cand = v_sum[RRW-1:0];
            if (!w_dfound && w_dreq[v_cand]) begin
                w_dfound = 1'b1;
                w_dsel   = v_cand;
            end
            if (!w_ifound && iREN[v_cand]) begin
                w_ifound = 1'b1;
                w_isel   = v_cand;
            end
        end
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            DGRANT: begin
                ramaddr        = daddr[r_owner];
                ramstore       = dstore[r_owner];
                ramWEN         = dWEN[r_owner];
                ramREN         = dREN[r_owner] & ~dWEN[r_owner];
                dwait[r_owner] = ~w_complete;
                dload[r_owner] = ramload;
            end
            IGRANT: begin
                ramaddr        = iaddr[r_owner];
                ramREN         = iREN[r_owner];
                iwait[r_owner] = ~w_complete;
                iload[r_owner] = ramload;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_rr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dfound) begin
                        r_state <= DGRANT;
                        r_owner <= w_dsel;
                    end else if (w_ifound) begin
                        r_state <= IGRANT;
                        r_owner <= w_isel;
                    end
                end
                DGRANT: begin
                    // Word 0 of a block keeps the grant so word 1 follows with no bubble.
                    if (w_complete) begin
                        if (daddr[r_owner][2]) begin
                            r_state <= IDLE;
                            r_rr    <= w_rr_next;
                        end
                    end else if (!w_dreq[r_owner]) begin
                        r_state <= IDLE;
                        r_rr    <= w_rr_next;
                    end
                end
                IGRANT: begin
                    if (w_complete || !iREN[r_owner]) begin
                        r_state <= IDLE;
                        r_rr    <= w_rr_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
